// File: rtl/rbi_mmu_chk_acc.sv
// rbi_mmu_chk_acc: TLB access-rights check producing a fault code and denied-rights vector
module rbi_mmu_chk_acc (
  input  logic        clock,
  input  logic        reset,
  input  logic        regInHold,
  input  logic [63:0] regInMMCR,
  input  logic [63:0] regInKRR,
  input  logic [63:0] regInSR,
  input  logic [7:0]  regInOpm,
  input  logic [31:0] tlbAcc,
  output logic [15:0] tTlbExc,
  output logic [5:0]  tChkAccNoRwx
);
  logic [7:0]  opm_q, opm_d;
  logic        usr, nr, nw, nx, s, key_ok, idle;
  logic [15:0] key;
  logic        unused_ok;
  // opcode stage: delays the request one cycle so it lines up with tlbAcc
  always_comb opm_d = !reset ? 8'h00 : regInHold ? opm_q : regInOpm;
  // opcode register
  always_ff @(posedge clock) opm_q <= opm_d;
  // rights and fault decode, purely combinational on the aligned opcode
  always_comb begin
    usr          = !regInSR[30];
    nr           = tlbAcc[0];
    nw           = tlbAcc[1];
    nx           = tlbAcc[2];
    s            = tlbAcc[3];
    key          = tlbAcc[31:16];
    key_ok       = key == 16'h0 || key == regInKRR[15:0] || key == regInKRR[31:16] ||
                   key == regInKRR[47:32] || key == regInKRR[63:48] || !usr;
    tChkAccNoRwx = {nx | s, nw | s, nr | s,
                    {nx, nw, nr} | {3{(s & usr) | !key_ok}}};
    idle         = !regInMMCR[0] || (regInSR[29] && regInSR[28]) || opm_q[4:3] == 2'b00;
    tTlbExc      = idle                          ? 16'h0000 :
                   usr && s                      ? 16'hA006 :
                   !key_ok                       ? 16'hA005 :
                   opm_q[5] && opm_q[4] && nx    ? 16'hA004 :
                   opm_q[4] && !opm_q[5] && nr   ? 16'hA002 :
                   opm_q[3] && nw                ? 16'hA003 : 16'h0000;
  end
  assign unused_ok = ^{regInMMCR[63:1], regInSR[63:31], regInSR[27:0], tlbAcc[15:4],
                       opm_q[7:6], opm_q[2:0]};
endmodule

// File: tb/tb_rbi_mmu_chk_acc.sv
// tb_rbi_mmu_chk_acc: directed self-checking bench for rbi_mmu_chk_acc
module tb_rbi_mmu_chk_acc;
  logic        clock = 1'b0;
  logic        reset, regInHold;
  logic [63:0] regInMMCR, regInKRR, regInSR;
  logic [7:0]  regInOpm;
  logic [31:0] tlbAcc;
  logic [15:0] tTlbExc;
  logic [5:0]  tChkAccNoRwx;
  int          n_cmp = 0;
  int          n_bad = 0;

  rbi_mmu_chk_acc dut (
    .clock(clock), .reset(reset), .regInHold(regInHold), .regInMMCR(regInMMCR),
    .regInKRR(regInKRR), .regInSR(regInSR), .regInOpm(regInOpm), .tlbAcc(tlbAcc),
    .tTlbExc(tTlbExc), .tChkAccNoRwx(tChkAccNoRwx)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [15:0] exc, input logic [5:0] rwx);
    chk({tag, "_exc"}, tTlbExc, exc);
    chk({tag, "_rwx"}, {10'd0, tChkAccNoRwx}, {10'd0, rwx});
  endtask

  initial begin
    reset = 1'b0; regInHold = 1'b0; regInMMCR = 64'd1; regInKRR = 64'd0;
    regInSR = 64'd0; regInOpm = 8'h10; tlbAcc = 32'h1;
    tick(); tick();
    chk2("reset", 16'h0000, 6'b001001);
    regInHold = 1'b1; tick();
    chk2("reset_hold", 16'h0000, 6'b001001);
    // V1
    reset = 1'b1; regInHold = 1'b0; tick();
    chk2("v1_read", 16'hA002, 6'b001001);
    // V2
    regInSR = 64'h4000_0000; regInOpm = 8'h08; tlbAcc = 32'h2; tick();
    chk2("v2_write", 16'hA003, 6'b010010);
    tlbAcc = 32'h0; settle();
    chk2("v2_ok", 16'h0000, 6'b000000);
    // V3
    regInSR = 64'd0; tlbAcc = 32'h1234_0000; regInKRR = 64'h0000_0000_1234_0000; settle();
    chk2("v3_key1", 16'h0000, 6'b000000);
    regInKRR = 64'd0; settle();
    chk2("v3_nokey", 16'hA005, 6'b000111);
    regInSR = 64'h4000_0000; settle();
    chk2("v3_sup", 16'h0000, 6'b000000);
    regInSR = 64'd0; regInKRR = 64'h1234_0000_0000_0000; settle();
    chk2("v3_key3", 16'h0000, 6'b000000);
    regInKRR = 64'h0000_1234_0000_0000; settle();
    chk2("v3_key2", 16'h0000, 6'b000000);
    regInKRR = 64'h0000_0000_0000_1234; settle();
    chk2("v3_key0", 16'h0000, 6'b000000);
    regInKRR = 64'h0000_0000_0000_1235; settle();
    chk2("v3_keyx", 16'hA005, 6'b000111);
    // V4
    regInKRR = 64'd0; tlbAcc = 32'h8; regInOpm = 8'h30; tick();
    chk2("v4_sfault", 16'hA006, 6'b111111);
    regInSR = 64'h4000_0000; settle();
    chk2("v4_sup", 16'h0000, 6'b111000);
    // V5
    regInSR = 64'd0; tlbAcc = 32'h7; regInOpm = 8'h10; tick();
    chk2("v5_base", 16'hA002, 6'b111111);
    regInMMCR = 64'd0; settle();
    chk2("v5_mmuoff", 16'h0000, 6'b111111);
    regInMMCR = 64'd1; regInSR = 64'h3000_0000; settle();
    chk2("v5_isr", 16'h0000, 6'b111111);
    regInSR = 64'h2000_0000; settle();
    chk2("v5_sr29", 16'hA002, 6'b111111);
    // execute and swap priority
    regInSR = 64'd0; tlbAcc = 32'h4; regInOpm = 8'h30; tick();
    chk2("exec", 16'hA004, 6'b100100);
    tlbAcc = 32'h1; settle();
    chk2("exec_nr", 16'h0000, 6'b001001);
    tlbAcc = 32'h3; regInOpm = 8'h18; tick();
    chk2("swap_rw", 16'hA002, 6'b011011);
    tlbAcc = 32'h2; settle();
    chk2("swap_w", 16'hA003, 6'b010010);
    // V6
    regInOpm = 8'h00; tlbAcc = 32'h1; tick();
    chk2("v6_idle", 16'h0000, 6'b001001);
    regInHold = 1'b1; regInOpm = 8'h10; tick(); tick();
    chk2("v6_held", 16'h0000, 6'b001001);
    regInHold = 1'b0; tick();
    chk2("v6_release", 16'hA002, 6'b001001);
    regInHold = 1'b1; regInOpm = 8'h00; tick();
    chk2("v6_hold_keep", 16'hA002, 6'b001001);
    tlbAcc = 32'h2; settle();
    chk2("v6_hold_track", 16'h0000, 6'b010010);
    tlbAcc = 32'h1; regInOpm = 8'h08; reset = 1'b0; tick();
    chk2("v6_rst_hold", 16'h0000, 6'b001001);
    reset = 1'b1; tlbAcc = 32'h2; tick();
    chk2("v6_post_rst_held", 16'h0000, 6'b010010);
    regInHold = 1'b0; tick();
    chk2("v6_post_rst_go", 16'hA003, 6'b010010);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rbi_mmu_chk_acc.md
RBI_MMU_CHK_ACC -- requirements
Module: rbi_mmu_chk_acc

Interface
REQ-001 The block SHALL have exactly one clock, `clock`, with all state updated on its rising edge.
REQ-002 `reset` SHALL be a synchronous, active-low reset input.
REQ-003 The ports SHALL be, in order:
- clock  in  1  clock
- reset  in  1  synchronous active-low reset
- regInHold  in  1  pipeline hold
- regInMMCR  in  64  MMU control
- regInKRR  in  64  keyring: four 16-bit keys at [15:0], [31:16], [47:32], [63:48]
- regInSR  in  64  status register
- regInOpm  in  8  request opcode
- tlbAcc  in  32  access word of the hit TLB entry
- tTlbExc  out  16  exception code; bit 15 set = fault
- tChkAccNoRwx  out  6  denied-rights vector

REQ-004 The regInOpm fields SHALL be: [4] read/load, [3] write/store, [5] execute (instruction fetch); opm[4:3]==0 means no memory access.
REQ-005 The tlbAcc fields SHALL be:
- [0] NR (no read), [1] NW (no write), [2] NX (no execute)
- [3] S: supervisor-only
- [15:4] reserved, ignored
- [31:16] access key; 0 = unkeyed

REQ-006 The regInSR fields SHALL be: SR[30] = supervisor mode; SR[29] and SR[28] both set = interrupt-service mode. regInMMCR[0] = MMU enable.

Function
REQ-007 The block SHALL register regInOpm into an internal opmQ on each clock edge where regInHold==0, and SHALL hold opmQ when regInHold==1. This aligns opmQ with tlbAcc, which arrives one stage later.
REQ-008 tlbAcc, SR, KRR and MMCR SHALL be used combinationally; both outputs SHALL be combinational functions of opmQ and these inputs, with no further latency.
REQ-009 The effective-user flag usr SHALL equal !SR[30].
REQ-010 The key-ok flag keyOk SHALL be 1 when acc[31:16]==0, or when acc[31:16] equals any of the four KRR keys, or when usr==0; otherwise keyOk SHALL be 0.
REQ-011 tChkAccNoRwx SHALL be formed as follows:
- [0] = NR | (S & usr) | !keyOk
- [1] = NW | (S & usr) | !keyOk
- [2] = NX | (S & usr) | !keyOk
- [3] = NR | S
- [4] = NW | S
- [5] = NX | S  (bits [5:3] are the user-mode view)

REQ-012 The fault code SHALL be selected in the priority order below, first match wins:
- a) MMCR[0]==0, or SR[29]&SR[28], or opmQ[4:3]==0 → 0x0000
- b) usr & S → 0xA006 (supervisor fault)
- c) !keyOk → 0xA005 (key fault)
- d) opmQ[5] & opmQ[4] & NX → 0xA004 (execute fault)
- e) opmQ[4] & !opmQ[5] & NR → 0xA002 (read fault)
- f) opmQ[3] & NW → 0xA003 (write fault)
- g) otherwise → 0x0000

REQ-013 For a swap (opm[4:3]==2'b11), rule (e) SHALL take precedence over rule (f).
REQ-014 tChkAccNoRwx SHALL be produced even when tTlbExc==0; it SHALL NOT be gated by MMCR, ISR, or opm.
REQ-015 When regInHold==1 across several cycles, the outputs SHALL track changes on tlbAcc, SR, KRR and MMCR combinationally while opmQ stays frozen.

Reset
REQ-016 When reset==0 at a clock edge, opmQ SHALL become 0x00, regardless of regInHold.
REQ-017 While opmQ==0, tTlbExc SHALL be 0x0000; tChkAccNoRwx SHALL still follow tlbAcc per REQ-011.
REQ-018 A reset asserted mid-hold SHALL clear opmQ, and the first request after reset release SHALL need one unheld edge to become visible.

Verification
REQ-019 The bench SHALL cover at least these directed scenarios:
- V1: MMCR=1, SR[30]=0, opm=0x10 then next cycle acc=0x00000001 → tTlbExc=0xA002, NoRwx=6'b001001.
- V2: MMCR=1, SR[30]=1, opm=0x08, acc=0x00000002 → 0xA003; same with acc=0 → 0x0000, NoRwx=0.
- V3: SR[30]=0, acc=0x12340000, KRR=0x0000_0000_1234_0000 → 0x0000; KRR=0 → 0xA005, NoRwx[2:0]=3'b111; SR[30]=1 → 0x0000.
- V4: SR[30]=0, acc=0x00000008, opm=0x30 → 0xA006; SR[30]=1 → 0x0000, NoRwx=6'b111000.
- V5: MMCR=0 or SR[29:28]=2'b11 with acc=0x7 and opm=0x10 → 0x0000, NoRwx still 6'b111111 in user mode.
- V6: opm=0x10 clocked with regInHold=1 → opmQ unchanged and tTlbExc stays 0; then reset=0 with opmQ=0x10 → next cycle tTlbExc=0x0000.
